// File: rtl/display_arbiter.sv
// Arbitrates the 4-digit seven-segment display between run, edit and alarm views.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero tens digits in RUN/EDIT views.
module display_arbiter #(
  parameter int unsigned BLINK_HALF = 50000,
  parameter int unsigned ALARM_HOLD = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_run,
  input  logic [15:0] run_digits,
  input  logic        req_edit,
  input  logic [15:0] edit_digits,
  input  logic [1:0]  edit_cursor,
  input  logic        alarm_pulse,
  input  logic        alarm_cancel,
  output logic [1:0]  grant,
  output logic [3:0]  digit_3,
  output logic [3:0]  digit_2,
  output logic [3:0]  digit_1,
  output logic [3:0]  digit_0,
  output logic        enable_3,
  output logic        enable_2,
  output logic        enable_1,
  output logic        enable_0
);

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_RUN   = 2'd1,
    G_EDIT  = 2'd2,
    G_ALARM = 2'd3
  } grant_t;

  localparam int unsigned CW = $clog2(BLINK_HALF);
  localparam int unsigned TW = $clog2(ALARM_HOLD);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(ALARM_HOLD - 1);

  grant_t        r_grant;
  logic          r_alarm_active;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [15:0]   r_digits;
  logic [3:0]    r_enables;

  logic          w_alarm_next;
  logic [TW-1:0] w_timer_next;
  grant_t        w_grant_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_phase_next;
  logic [15:0]   w_digits_next;
  logic [3:0]    w_en_next;

  // Cancel beats a same-cycle pulse; a pulse during an active alarm restarts the hold.
  always_comb begin
    w_alarm_next = r_alarm_active;
    w_timer_next = r_timer;
    if (alarm_cancel) begin
      w_alarm_next = 1'b0;
      w_timer_next = '0;
    end else if (alarm_pulse) begin
      w_alarm_next = 1'b1;
      w_timer_next = HOLD_LOAD;
    end else if (r_alarm_active) begin
      if (r_timer == '0) w_alarm_next = 1'b0;
      else               w_timer_next = r_timer - TW'(1);
    end
  end

  always_comb begin
    if (w_alarm_next)  w_grant_next = G_ALARM;
    else if (req_edit) w_grant_next = G_EDIT;
    else if (req_run)  w_grant_next = G_RUN;
    else               w_grant_next = G_IDLE;
  end

  // A new owner restarts the blink so it is first shown visible.
  always_comb begin
    w_cnt_next   = r_blink_cnt + CW'(1);
    w_phase_next = r_phase;
    if (w_grant_next != r_grant) begin
      w_cnt_next   = '0;
      w_phase_next = 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      w_cnt_next   = '0;
      w_phase_next = ~r_phase;
    end
  end

  always_comb begin
    w_digits_next = '0;
    w_en_next     = '0;
    case (w_grant_next)
      G_RUN: begin
        w_digits_next = run_digits;
        w_en_next     = '1;
      end
      G_EDIT: begin
        w_digits_next = edit_digits;
        w_en_next     = '1;
        w_en_next[edit_cursor] = w_phase_next;
      end
      G_ALARM: begin
        w_digits_next = run_digits;
        w_en_next     = {4{w_phase_next}};
      end
      default: begin
        w_digits_next = '0;
        w_en_next     = '0;
      end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((w_grant_next == G_RUN) || (w_grant_next == G_EDIT)) begin
      if (w_digits_next[15:12] == 4'd0) w_en_next[3] = 1'b0;
      if (w_digits_next[7:4]   == 4'd0) w_en_next[1] = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant        <= G_IDLE;
      r_alarm_active <= 1'b0;
      r_timer        <= '0;
      r_blink_cnt    <= '0;
      r_phase        <= 1'b1;
      r_digits       <= '0;
      r_enables      <= '0;
    end else begin
      r_grant        <= w_grant_next;
      r_alarm_active <= w_alarm_next;
      r_timer        <= w_timer_next;
      r_blink_cnt    <= w_cnt_next;
      r_phase        <= w_phase_next;
      r_digits       <= w_digits_next;
      r_enables      <= w_en_next;
    end
  end

  assign grant    = r_grant;
  assign digit_3  = r_digits[15:12];
  assign digit_2  = r_digits[11:8];
  assign digit_1  = r_digits[7:4];
  assign digit_0  = r_digits[3:0];
  assign enable_3 = r_enables[3];
  assign enable_2 = r_enables[2];
  assign enable_1 = r_enables[1];
  assign enable_0 = r_enables[0];

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed scenarios plus random traffic against a cycle-count model.
module tb_display_arbiter;
  localparam int BH   = 4;
  localparam int HOLD = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_run = 1'b0, req_edit = 1'b0;
  logic [15:0] run_digits = '0, edit_digits = '0;
  logic [1:0]  edit_cursor = '0;
  logic        alarm_pulse = 1'b0, alarm_cancel = 1'b0;
  logic [1:0]  grant;
  logic [3:0]  digit_3, digit_2, digit_1, digit_0;
  logic        enable_3, enable_2, enable_1, enable_0;

  display_arbiter #(.BLINK_HALF(BH), .ALARM_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst),
    .req_run(req_run), .run_digits(run_digits),
    .req_edit(req_edit), .edit_digits(edit_digits), .edit_cursor(edit_cursor),
    .alarm_pulse(alarm_pulse), .alarm_cancel(alarm_cancel),
    .grant(grant),
    .digit_3(digit_3), .digit_2(digit_2), .digit_1(digit_1), .digit_0(digit_0),
    .enable_3(enable_3), .enable_2(enable_2), .enable_1(enable_1), .enable_0(enable_0)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: absolute edge index, alarm end edge, cycles since the owner last changed.
  int          n = 0;
  int          alarm_end = 0;
  int          since = 0;
  int          m_grant = 0;
  bit          m_phase = 1'b1;
  logic [15:0] m_digits = '0;
  logic [3:0]  m_en = '0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant = 0; alarm_end = 0; since = 0; m_phase = 1'b1;
    m_digits = '0; m_en = '0;
  endtask

  task automatic model_edge();
    int g;
    n++;
    if (rst) begin
      model_reset();
      return;
    end
    if (alarm_cancel)     alarm_end = 0;
    else if (alarm_pulse) alarm_end = n + HOLD;
    if (n < alarm_end)  g = 3;
    else if (req_edit)  g = 2;
    else if (req_run)   g = 1;
    else                g = 0;
    if (g != m_grant) since = 0;
    else              since++;
    m_grant = g;
    m_phase = ((since / BH) % 2) == 0;
    m_digits = '0;
    m_en = '0;
    if (g == 1) begin
      m_digits = run_digits; m_en = 4'hF;
    end else if (g == 2) begin
      m_digits = edit_digits; m_en = 4'hF; m_en[edit_cursor] = m_phase;
    end else if (g == 3) begin
      m_digits = run_digits; m_en = m_phase ? 4'hF : 4'h0;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (g == 1 || g == 2) begin
      if (m_digits[15:12] == 4'd0) m_en[3] = 1'b0;
      if (m_digits[7:4]   == 4'd0) m_en[1] = 1'b0;
    end
`endif
  endtask

  task automatic check_all();
    chk("grant",   int'(grant), m_grant);
    chk("digits",  int'({digit_3, digit_2, digit_1, digit_0}), int'(m_digits));
    chk("enables", int'({enable_3, enable_2, enable_1, enable_0}), int'(m_en));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    alarm_pulse  = 1'b0;
    alarm_cancel = 1'b0;
  endtask

  function automatic int en_vec();
    return int'({enable_3, enable_2, enable_1, enable_0});
  endfunction

  initial begin
    int cnt;
    repeat (2) step();
    rst = 1'b0;

    // Reset mid-operation
    req_run = 1'b1; run_digits = 16'h1234;
    repeat (3) step();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    chk("rst_grant", int'(grant), 0);
    chk("rst_en", en_vec(), 0);
    req_run = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("idle_grant", int'(grant), 0);
    chk("idle_en", en_vec(), 0);
    chk("idle_digits", int'({digit_3, digit_2, digit_1, digit_0}), 0);

    // Run view
    req_run = 1'b1; run_digits = 16'h4237;
    step();
    chk("run_grant", int'(grant), 1);
    chk("run_digits", int'({digit_3, digit_2, digit_1, digit_0}), 16'h4237);
    chk("run_en", en_vec(), 4'hF);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (grant == 2'd1 && en_vec() == 4'hF) cnt++;
    end
    chk("run_steady", cnt, 50);

    // Edit preemption and cursor blink
    req_edit = 1'b1; edit_digits = 16'h0500; edit_cursor = 2'd2;
    step();
    chk("edit_grant", int'(grant), 2);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      chk("edit_blink", int'(enable_2), (i < 4 || (i >= 8 && i < 12)) ? 1 : 0);
    end
    req_edit = 1'b0;
    step();
    chk("edit_drop", int'(grant), 1);

    // Alarm hold with restart
    run_digits = 16'h3000; alarm_pulse = 1'b1;
    step();
    chk("alarm_grant", int'(grant), 3);
    repeat (9) step();
    alarm_pulse = 1'b1;
    step();
    cnt = (grant == 2'd3) ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (grant != 2'd3) break;
      cnt++;
    end
    chk("alarm_hold", cnt, 20);
    chk("alarm_fallback", int'(grant), 1);

    // Cancel vs pulse collision, then early cancel
    req_edit = 1'b1; edit_cursor = 2'd2;
    alarm_pulse = 1'b1; alarm_cancel = 1'b1;
    step();
    chk("collide_grant", int'(grant), 2);
    repeat (3) step();
    alarm_pulse = 1'b1;
    step();
    chk("alarm2_grant", int'(grant), 3);
    repeat (4) step();
    alarm_cancel = 1'b1;
    step();
    chk("cancel_grant", int'(grant), 2);
    chk("cancel_cursor", int'(enable_2), 1);

    // Leading-zero blanking
    req_edit = 1'b0; run_digits = 16'h0507;
    step();
`ifdef LEADING_ZERO_BLANK_EN
    chk("lzb_en", en_vec(), 4'b0101);
`else
    chk("lzb_en", en_vec(), 4'b1111);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      req_run      = ($urandom % 4) != 0;
      req_edit     = ($urandom % 3) == 0;
      run_digits   = 16'($urandom);
      edit_digits  = 16'($urandom);
      edit_cursor  = 2'($urandom);
      alarm_pulse  = ($urandom % 40) == 0;
      alarm_cancel = ($urandom % 80) == 0;
      if (($urandom % 500) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        step();
        rst = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 4-digit seven-segment display between three requesters: countdown run view, keypad entry/edit view, and expiry alarm flash.
- Sits between the countdown logic and the display scan block, driving its digit_3..digit_0 and enable_3..enable_0 inputs.
- Owns the priority decision, alarm hold timing and blink sequencing.
- Runs on the logic clock domain (100 kHz nominal).

Parameters:
- BLINK_HALF, 50000: clk cycles per blink half-period (0.5 s at 100 kHz); legal range is 2 or more.
- ALARM_HOLD, 200000: clk cycles the alarm view is held after alarm_pulse (2 s); legal range is 2 or more.

Ports:
- clk  in  1  logic clock.
- rst  in  1  asynchronous active-high reset.
- req_run  in  1  countdown view requested (level).
- run_digits  in  16  run view BCD, [15:12]=digit_3 .. [3:0]=digit_0.
- req_edit  in  1  entry view requested (level).
- edit_digits  in  16  entry view BCD, same packing.
- edit_cursor  in  2  index of the digit being edited (0..3); this digit blinks.
- alarm_pulse  in  1  one-cycle strobe when the countdown reaches zero.
- alarm_cancel  in  1  one-cycle strobe (clear key) that ends the alarm early.
- grant  out  2  current owner: 0=IDLE, 1=RUN, 2=EDIT, 3=ALARM.
- digit_3, digit_2, digit_1, digit_0  out  4 each  BCD to the display block.
- enable_3, enable_2, enable_1, enable_0  out  1 each  digit enables.

Behaviour:
- Reset (async, immediate): grant=IDLE, all digits=0, all enables=0, blink phase=1 (visible), blink counter=0, alarm timer=0, alarm_active=0.
- Alarm tracking:
  - alarm_pulse sets alarm_active and loads the timer with ALARM_HOLD-1.
  - The timer decrements each cycle; alarm_active clears when the timer is 0.
  - alarm_pulse while alarm_active reloads the timer (the hold restarts).
  - alarm_cancel clears alarm_active and wins over alarm_pulse in the same cycle.
- Priority, evaluated every cycle: alarm_active, then req_edit, then req_run, otherwise IDLE. Preemption is immediate; there is no hysteresis.
- Blink:
  - The counter counts 0..BLINK_HALF-1; phase toggles on wrap.
  - Any change of the next grant resets the counter to 0 and phase to 1, so a new owner is first shown visible.
- All outputs are registered, with exactly 1 cycle latency from inputs and grant to digits and enables.
- View content per grant:
  - IDLE: all digits 0, all enables 0.
  - RUN: digits=run_digits; all enables 1.
  - EDIT: digits=edit_digits; enables 1 except enable[edit_cursor]=phase.
  - ALARM: digits=run_digits; all four enables=phase (whole display flashes).
- Input digits are passed through unchecked; values 10..15 reach the display unchanged.
- When the alarm expires or is cancelled, grant falls back in the same cycle to whichever of EDIT/RUN/IDLE is requested.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in RUN and EDIT views, enable_3 is forced 0 when digit_3 is 0, and enable_1 is forced 0 when digit_1 is 0. The tens digit of each two-digit pair is blanked. This is ANDed with any cursor blink.
- Not defined: enables follow Behaviour exactly; zeros are displayed.
- ALARM view is unaffected in both cases.

Test Plan (BLINK_HALF=4, ALARM_HOLD=20):
- Reset and idle: assert rst mid-operation, then release with no requests -> grant=0, enables all 0, digits 0 at once and on the cycle after release.
- Run view: req_run=1, run_digits=16'h4237 -> 1 cycle later grant=1, digits 4,2,3,7, enables 1111, steady for 50 cycles.
- Edit preemption and blink: req_run=1 and req_edit=1, edit_digits=16'h0500, edit_cursor=2 -> grant=2. enable_2 is 1 for 4 cycles, 0 for 4 cycles, repeating; the other enables stay 1. Drop req_edit -> grant=1 next cycle.
- Alarm hold and restart: alarm_pulse with req_run=1 and run_digits=16'h3000 -> grant=3 with all enables toggling every 4 cycles. A second pulse at cycle 10 extends ALARM to 20 cycles from the second pulse, after which grant=1.
- Cancel versus pulse collision: alarm_pulse and alarm_cancel in the same cycle with req_edit=1 -> grant stays 2 and the alarm never appears. A cancel 5 cycles into an alarm -> grant=2 next cycle, edit cursor visible (phase=1).
- LEADING_ZERO_BLANK_EN defined: RUN with run_digits=16'h0507 -> enables 0101. Without the macro -> 1111.
